// File: rtl/bus_oe_arbiter_if.sv
`timescale 1ns/1ps
// Shared-bus ownership signals between the arbiter and the 74574 register bank.
interface bus_oe_arbiter_if;
  logic [3:0] req;
  logic [3:0] oe_n;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       busy;
  logic       expired;

  modport master (input req, output oe_n, gnt_id, gnt_valid, busy, expired);
  modport slave  (output req, input oe_n, gnt_id, gnt_valid, busy, expired);
endinterface

// File: rtl/bus_oe_arbiter.sv
`timescale 1ns/1ps
// Round-robin owner of a shared 8-bit tri-state bus: drives the active-low _OE of four
// 74574 registers, one at a time, with a dead turnaround between owners and a hold limit.
module bus_oe_arbiter #(
  parameter int unsigned MAX_HOLD    = 8,
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned LOG         = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  bus_oe_arbiter_if.master bus
);
  localparam int unsigned NumReq = 4;
  localparam int unsigned IdW    = 2;
  localparam int unsigned HoldW  = 8;
  localparam int unsigned TurnW  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  state_e            state_q;
  logic [IdW-1:0]    last_q;
  logic [IdW-1:0]    owner_q;
  logic [HoldW-1:0]  hold_q;
  logic [TurnW-1:0]  turn_q;
  logic [NumReq-1:0] oe_n_q;
  logic              gnt_valid_q;
  logic              busy_q;
  logic              expired_q;

  logic              win_found;
  logic [IdW-1:0]    win_id;
  logic [IdW-1:0]    cand;
  logic [NumReq-1:0] win_oe_n;

  // Out-of-range parameters are rejected at elaboration.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("bus_oe_arbiter: MAX_HOLD must be 1..255");
  end
  if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
    $error("bus_oe_arbiter: TURN_CYCLES must be 1..15");
  end
  if (LOG > 1) begin : g_bad_log
    $error("bus_oe_arbiter: LOG must be 0 or 1");
  end

  // Search starts just after the last winner so every active requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = last_q;
    cand      = last_q;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = last_q + IdW'(i);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
    win_oe_n = ~(NumReq'(1) << win_id);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      last_q      <= IdW'(NumReq - 1);
      owner_q     <= '0;
      hold_q      <= '0;
      turn_q      <= '0;
      oe_n_q      <= '1;
      gnt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            state_q     <= ST_GRANT;
            owner_q     <= win_id;
            last_q      <= win_id;
            hold_q      <= HoldW'(1);
            oe_n_q      <= win_oe_n;
            gnt_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (!bus.req[owner_q] || hold_q == HoldW'(MAX_HOLD)) begin
            state_q     <= ST_TURN;
            turn_q      <= TurnW'(1);
            oe_n_q      <= '1;
            gnt_valid_q <= 1'b0;
            expired_q   <= bus.req[owner_q];
          end else begin
            hold_q <= hold_q + HoldW'(1);
          end
        end
        ST_TURN: begin
          if (turn_q < TurnW'(TURN_CYCLES)) begin
            turn_q <= turn_q + TurnW'(1);
          end else if (win_found) begin
            state_q     <= ST_GRANT;
            owner_q     <= win_id;
            last_q      <= win_id;
            hold_q      <= HoldW'(1);
            oe_n_q      <= win_oe_n;
            gnt_valid_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          oe_n_q      <= '1;
          gnt_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oe_n      = oe_n_q;
  assign bus.gnt_id    = owner_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.busy      = busy_q;
  assign bus.expired   = expired_q;

endmodule

// File: tb/tb_bus_oe_arbiter.sv
`timescale 1ns/1ps
// Bench for bus_oe_arbiter: three parameterisations, directed tables/sequences and
// randomized traffic compared every cycle against an ownership-level reference model.
module tb_bus_oe_arbiter;
  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_v [NDUT];
  int         nvec = 0;
  int         nerr = 0;
  bit         chk_en = 1'b0;

  always #5 clk = ~clk;

  bus_oe_arbiter_if if0 ();
  bus_oe_arbiter_if if1 ();
  bus_oe_arbiter_if if2 ();
  assign if0.req = req_v[0];
  assign if1.req = req_v[1];
  assign if2.req = req_v[2];

  bus_oe_arbiter #(.MAX_HOLD(8), .TURN_CYCLES(1), .LOG(0)) u0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  bus_oe_arbiter #(.MAX_HOLD(2), .TURN_CYCLES(1), .LOG(0)) u1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  bus_oe_arbiter #(.MAX_HOLD(8), .TURN_CYCLES(3), .LOG(0)) u2 (.clk_i(clk), .rst_i(rst), .bus(if2));

  logic [3:0] oe_a [NDUT];
  logic [1:0] id_a [NDUT];
  logic       v_a  [NDUT];
  logic       b_a  [NDUT];
  logic       x_a  [NDUT];
  assign oe_a[0] = if0.oe_n;  assign id_a[0] = if0.gnt_id;  assign v_a[0] = if0.gnt_valid;
  assign b_a[0]  = if0.busy;  assign x_a[0]  = if0.expired;
  assign oe_a[1] = if1.oe_n;  assign id_a[1] = if1.gnt_id;  assign v_a[1] = if1.gnt_valid;
  assign b_a[1]  = if1.busy;  assign x_a[1]  = if1.expired;
  assign oe_a[2] = if2.oe_n;  assign id_a[2] = if2.gnt_id;  assign v_a[2] = if2.gnt_valid;
  assign b_a[2]  = if2.busy;  assign x_a[2]  = if2.expired;

  function automatic int cfg_hold(input int k);
    return (k == 1) ? 2 : 8;
  endfunction
  function automatic int cfg_turn(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  // Model: who owns the bus, for how long, and how long the bus has been dead.
  typedef struct {
    int owner;
    int held;
    int dead;
    int last;
    bit exp;
  } mdl_t;
  mdl_t m [NDUT];

  function automatic int pick(input logic [3:0] r, input int last);
    for (int j = 1; j <= 4; j++) if (r[(last + j) % 4]) return (last + j) % 4;
    return -1;
  endfunction

  function automatic mdl_t step(input mdl_t cur, input logic [3:0] r, input logic rs,
                                input int maxh, input int turn);
    mdl_t n;
    int   w;
    n = cur;
    n.exp = 1'b0;
    if (rs) begin
      n.owner = -1; n.held = 0; n.dead = 0; n.last = 3;
      return n;
    end
    if (cur.owner >= 0) begin
      if (!r[cur.owner] || cur.held == maxh) begin
        n.exp = r[cur.owner];
        n.owner = -1;
        n.dead = 1;
      end else begin
        n.held = cur.held + 1;
      end
    end else if (cur.dead == 0 || cur.dead >= turn) begin
      w = pick(r, cur.last);
      n.dead = 0;
      if (w >= 0) begin
        n.owner = w; n.held = 1; n.last = w;
      end
    end else begin
      n.dead = cur.dead + 1;
    end
    return n;
  endfunction

  always @(posedge clk)
    for (int k = 0; k < NDUT; k++) m[k] = step(m[k], req_v[k], rst, cfg_hold(k), cfg_turn(k));

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL u%0d %s: got %0h expected %0h at %0t", k, nm, act, exp, $time);
    end
  endtask

  logic [3:0] prev_oe [NDUT];
  logic [3:0] e_oe;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NDUT; k++) begin
        e_oe = (m[k].owner < 0) ? 4'hF : ~(4'b0001 << m[k].owner);
        chk("model_oe", k, 8'(oe_a[k]), 8'(e_oe));
        chk("model_valid", k, 8'(v_a[k]), 8'(m[k].owner >= 0));
        chk("model_busy", k, 8'(b_a[k]), 8'((m[k].owner >= 0) || (m[k].dead > 0)));
        chk("model_expired", k, 8'(x_a[k]), 8'(m[k].exp));
        if (m[k].owner >= 0) chk("model_id", k, 8'(id_a[k]), 8'(m[k].owner));
        chk("onehot", k, 8'($countones(~oe_a[k]) <= 1), 8'd1);
        if (prev_oe[k] != 4'hF && oe_a[k] != 4'hF) chk("handover", k, 8'(oe_a[k]), 8'(prev_oe[k]));
        prev_oe[k] = oe_a[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic see(input int k, input string nm, input logic [3:0] oe, input logic v, input logic b);
    chk({nm, "_oe"}, k, 8'(oe_a[k]), 8'(oe));
    chk({nm, "_valid"}, k, 8'(v_a[k]), 8'(v));
    chk({nm, "_busy"}, k, 8'(b_a[k]), 8'(b));
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] oe;
    logic       v;
    logic       b;
    logic       x;
    logic [1:0] id;
  } vec_t;
  vec_t rr [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // MAX_HOLD=2, TURN_CYCLES=1, all requesting: 0,1,2,3,0 each for 2 cycles, 1 dead cycle between.
    rr[0]  = '{4'hF, 4'hE, 1'b1, 1'b1, 1'b0, 2'd0};
    rr[1]  = '{4'hF, 4'hE, 1'b1, 1'b1, 1'b0, 2'd0};
    rr[2]  = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0};
    rr[3]  = '{4'hF, 4'hD, 1'b1, 1'b1, 1'b0, 2'd1};
    rr[4]  = '{4'hF, 4'hD, 1'b1, 1'b1, 1'b0, 2'd1};
    rr[5]  = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0};
    rr[6]  = '{4'hF, 4'hB, 1'b1, 1'b1, 1'b0, 2'd2};
    rr[7]  = '{4'hF, 4'hB, 1'b1, 1'b1, 1'b0, 2'd2};
    rr[8]  = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0};
    rr[9]  = '{4'hF, 4'h7, 1'b1, 1'b1, 1'b0, 2'd3};
    rr[10] = '{4'hF, 4'h7, 1'b1, 1'b1, 1'b0, 2'd3};
    rr[11] = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0};
    rr[12] = '{4'hF, 4'hE, 1'b1, 1'b1, 1'b0, 2'd0};
    rr[13] = '{4'hF, 4'hE, 1'b1, 1'b1, 1'b0, 2'd0};
    rr[14] = '{4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0};
    rr[15] = '{4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0};

    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      req_v[k] = 4'h0;
      prev_oe[k] = 4'hF;
    end
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < NDUT; k++) see(k, "idle", 4'hF, 1'b0, 1'b0);

    // Round-robin table.
    for (int i = 0; i < 16; i++) begin
      req_v[1] = rr[i].req;
      tick();
      see(1, $sformatf("rr%0d", i), rr[i].oe, rr[i].v, rr[i].b);
      chk($sformatf("rr%0d_expired", i), 1, 8'(x_a[1]), 8'(rr[i].x));
      if (rr[i].v) chk($sformatf("rr%0d_id", i), 1, 8'(id_a[1]), 8'(rr[i].id));
    end

    // Single request held 3 cycles.
    req_v[0] = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      see(0, "single", 4'hE, 1'b1, 1'b1);
      chk("single_id", 0, 8'(id_a[0]), 8'd0);
    end
    req_v[0] = 4'b0000;
    tick();
    see(0, "single_dead", 4'hF, 1'b0, 1'b1);
    chk("single_noexp", 0, 8'(x_a[0]), 8'd0);
    tick();
    see(0, "single_idle", 4'hF, 1'b0, 1'b0);

    // Reset in the second cycle of a grant; regrant with no turnaround.
    req_v[0] = 4'b0100;
    tick();
    see(0, "mid", 4'hB, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    see(0, "mid_rst", 4'hF, 1'b0, 1'b0);
    chk("mid_rst_exp", 0, 8'(x_a[0]), 8'd0);
    rst = 1'b0;
    tick();
    see(0, "regrant", 4'hB, 1'b1, 1'b1);
    chk("regrant_id", 0, 8'(id_a[0]), 8'd2);
    req_v[0] = 4'b0000;
    tick();
    tick();
    see(0, "regrant_idle", 4'hF, 1'b0, 1'b0);

    // Non-owner churn while requester 1 owns the bus.
    req_v[0] = 4'b0010;
    tick();
    see(0, "churn", 4'hD, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      req_v[0] = (i % 2 == 0) ? 4'b1010 : 4'b0010;
      tick();
      see(0, "churn_hold", 4'hD, 1'b1, 1'b1);
    end
    req_v[0] = 4'b1000;
    tick();
    see(0, "churn_rel", 4'hF, 1'b0, 1'b1);
    tick();
    see(0, "churn_next", 4'h7, 1'b1, 1'b1);
    chk("churn_next_id", 0, 8'(id_a[0]), 8'd3);

    // Three-cycle turnaround.
    req_v[2] = 4'b0011;
    tick();
    see(2, "turn", 4'hE, 1'b1, 1'b1);
    req_v[2] = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      see(2, $sformatf("dead%0d", i), 4'hF, 1'b0, 1'b1);
    end
    tick();
    see(2, "turn_next", 4'hD, 1'b1, 1'b1);

    // Randomized traffic; the model checker compares every cycle.
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < NDUT; k++)
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 3) == 0) req_v[k][b] = ~req_v[k][b];
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
